axisv_frame_ctrl: RTL and testbench

Frame scheduler and stream monitor for the AXIS video test-pattern generator.
- Issues one-cycle trigger pulses to the generator, either one-shot or continuously at a programmable frame period.
- Taps the generator's AXIS output (tvalid, tready, tlast, tuser) passively and counts completed frames.
- Flags framing errors, stalled frames and period overruns.
- Sits between the PS-side control registers and the generator/LCD-sink pair.

---
 rtl/axisv_pkg.sv | 14 +
 rtl/axisv_beat_checker.sv | 77 +++++++
 rtl/axisv_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_axisv_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axisv_pkg.sv
// Shared types and constants for the AXIS video frame controller.
package axisv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    ACTIVE,
    WAIT
  } frame_state_e;

  // tuser bit carrying the end-of-frame marker.
  localparam int unsigned TUSER_EOF_BIT = 0;

endpackage

// File: rtl/axisv_beat_checker.sv
// Position tracker and framing checker for the monitored AXIS stream.
// Counts beats into col/row while the frame is active and compares the
// generator's tlast / tuser EOF markers against the expected position.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - zero col/row (asserted while the trigger is issued)
//   active     - a frame is being collected
//   beat       - tvalid & tready of the monitored stream
//   tlast      - monitored tlast (end of line)
//   tuser      - monitored tuser (EOF at TUSER_EOF_BIT)
//   last_beat  - current position is the final beat of the frame
//   line_err   - strobe: tlast disagrees with the column position
//   frame_err  - strobe: EOF disagrees with position, or beat outside a frame
module axisv_beat_checker
  import axisv_pkg::*;
#(
  parameter int unsigned H_PIXEL_COUNT = 8,
  parameter int unsigned V_PIXEL_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       active,
  input  logic       beat,
  input  logic       tlast,
  input  logic [1:0] tuser,
  output logic       last_beat,
  output logic       line_err,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(H_PIXEL_COUNT) + 1;
  localparam int unsigned RW = $clog2(V_PIXEL_COUNT) + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_PIXEL_COUNT - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_PIXEL_COUNT - 1);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          col_end;
  logic          eof;
  logic          unused_tuser;

  assign eof          = tuser[TUSER_EOF_BIT];
  assign unused_tuser = ^tuser;
  assign col_end      = (col_q == COL_LAST);
  assign last_beat    = col_end & (row_q == ROW_LAST);

  always_comb begin
    line_err  = 1'b0;
    frame_err = 1'b0;
    if (beat) begin
      if (active) begin
        line_err  = (tlast != col_end);
        frame_err = (eof != last_beat);
      end else begin
        // Any handshake outside a frame is stray data.
        frame_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (active && beat) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/axisv_frame_ctrl.sv
// Frame scheduler and passive stream monitor for the AXIS test-pattern
// generator. Issues one-cycle triggers (one-shot or periodic), counts
// completed frames and raises sticky framing / stall / overrun flags.
//
// Ports:
//   aclk_i, rst_i        - clock, synchronous active-high reset
//   enable_i             - continuous mode enable (level)
//   single_i             - one-shot request, honoured in IDLE
//   period_i             - trigger-to-trigger period in cycles (0 acts as 1)
//   clear_i              - clear sticky flags (new errors win)
//   trigger_o            - one-cycle start pulse to the generator
//   mon_t*_i             - monitored AXIS handshake and markers
//   busy_o               - frame in progress (TRIG/ACTIVE)
//   frame_done_o         - pulse on the final beat of a frame
//   frame_cnt_o          - completed frame count, wraps
//   err_line_o           - sticky tlast mismatch
//   err_frame_o          - sticky EOF mismatch or stray beat
//   err_timeout_o        - sticky frame stall
//   overrun_o            - sticky period elapsed before frame done
module axisv_frame_ctrl
  import axisv_pkg::*;
#(
  parameter int unsigned H_PIXEL_COUNT   = 8,
  parameter int unsigned V_PIXEL_COUNT   = 4,
  parameter int unsigned PERIOD_WIDTH    = 24,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                       aclk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       single_i,
  input  logic [PERIOD_WIDTH-1:0]    period_i,
  input  logic                       clear_i,
  output logic                       trigger_o,
  input  logic                       mon_tvalid_i,
  input  logic                       mon_tready_i,
  input  logic                       mon_tlast_i,
  input  logic [1:0]                 mon_tuser_i,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
  output logic                       err_line_o,
  output logic                       err_frame_o,
  output logic                       err_timeout_o,
  output logic                       overrun_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  frame_state_e            state_q;
  frame_state_e            state_d;
  logic                    beat;
  logic                    in_frame;
  logic                    last_beat;
  logic                    line_err;
  logic                    frame_err;
  logic                    frame_end;
  logic                    to_hit;
  logic                    ovr_hit;
  logic [PERIOD_WIDTH-1:0] period_max;
  logic [PERIOD_WIDTH-1:0] timer_q;
  logic                    period_end;
  logic [TW-1:0]           to_q;

  assign beat       = mon_tvalid_i & mon_tready_i;
  assign in_frame   = (state_q == ACTIVE);
  assign frame_end  = in_frame & beat & last_beat;
  // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a beat.
  assign to_hit     = in_frame & ~beat & (to_q == TO_LAST);
  assign period_max = (period_i == '0) ? '0 : period_i - PERIOD_WIDTH'(1);
  // >= keeps a live shrink of period_i from stranding the timer above the end.
  assign period_end = (timer_q >= period_max);
  assign ovr_hit    = ((state_q == TRIG) || in_frame) && period_end;

  axisv_beat_checker #(
    .H_PIXEL_COUNT(H_PIXEL_COUNT),
    .V_PIXEL_COUNT(V_PIXEL_COUNT)
  ) u_beat_checker (
    .clk      (aclk_i),
    .rst      (rst_i),
    .clear    (state_q == TRIG),
    .active   (in_frame),
    .beat     (beat),
    .tlast    (mon_tlast_i),
    .tuser    (mon_tuser_i),
    .last_beat(last_beat),
    .line_err (line_err),
    .frame_err(frame_err)
  );

  always_comb begin
    state_d      = state_q;
    trigger_o    = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i || single_i) state_d = TRIG;
      end
      TRIG: begin
        trigger_o = 1'b1;
        busy_o    = 1'b1;
        state_d   = ACTIVE;
      end
      ACTIVE: begin
        busy_o = 1'b1;
        if (frame_end) begin
          frame_done_o = 1'b1;
          state_d      = enable_i ? WAIT : IDLE;
        end else if (to_hit) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!enable_i)       state_d = IDLE;
        else if (period_end) state_d = TRIG;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      to_q          <= '0;
      frame_cnt_o   <= '0;
      err_line_o    <= 1'b0;
      err_frame_o   <= 1'b0;
      err_timeout_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      state_q <= state_d;

      // Cleared on entry so the timer reads 0 during TRIG and k k cycles later.
      if (state_d == TRIG)  timer_q <= '0;
      else if (!period_end) timer_q <= timer_q + PERIOD_WIDTH'(1);

      if (state_q == TRIG) to_q <= '0;
      else if (in_frame)   to_q <= beat ? '0 : to_q + TW'(1);

      if (frame_end) frame_cnt_o <= frame_cnt_o + FRAME_CNT_WIDTH'(1);

      err_line_o    <= line_err  | (err_line_o    & ~clear_i);
      err_frame_o   <= frame_err | (err_frame_o   & ~clear_i);
      err_timeout_o <= to_hit    | (err_timeout_o & ~clear_i);
      overrun_o     <= ovr_hit   | (overrun_o     & ~clear_i);
    end
  end

endmodule

// File: tb/tb_axisv_frame_ctrl.sv
module tb_axisv_frame_ctrl;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int NB  = H * V;
  localparam int PW  = 24;
  localparam int T   = 64;
  localparam int FCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, enable, single, clear;
  logic [PW-1:0]  period;
  logic           tvalid, tready, tlast;
  logic [1:0]     tuser;
  logic           trigger, busy, frame_done;
  logic [FCW-1:0] frame_cnt;
  logic           err_line, err_frame, err_timeout, overrun;

  axisv_frame_ctrl #(
    .H_PIXEL_COUNT(H), .V_PIXEL_COUNT(V), .PERIOD_WIDTH(PW),
    .TIMEOUT_CYCLES(T), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .aclk_i(clk), .rst_i(rst), .enable_i(enable), .single_i(single),
    .period_i(period), .clear_i(clear), .trigger_o(trigger),
    .mon_tvalid_i(tvalid), .mon_tready_i(tready), .mon_tlast_i(tlast),
    .mon_tuser_i(tuser), .busy_o(busy), .frame_done_o(frame_done),
    .frame_cnt_o(frame_cnt), .err_line_o(err_line), .err_frame_o(err_frame),
    .err_timeout_o(err_timeout), .overrun_o(overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus knobs
  bit en, single_req, clear_req, stray_on, clear_on_inj;
  int rst_cycles, p_valid, p_ready, p_fault, inj_line, stall_from, rst_at_idx;
  // Generator
  int gen_left, gen_idx;
  // Reference model: frame progress as beat index, period as elapsed time
  bit     m_trig, m_frame, m_wait;
  int     beat_idx, stall, frames;
  bit     f_line, f_frame, f_to, f_ov;
  longint cyc = 0, trig_cyc = 0, base = 0;
  longint trig_cycles[$], done_cycles[$];

  function automatic longint qat(input longint q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_trig = 0; m_frame = 0; m_wait = 0; beat_idx = 0; stall = 0; frames = 0;
    f_line = 0; f_frame = 0; f_to = 0; f_ov = 0;
  endtask

  task automatic drive();
    rst = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    single = single_req; single_req = 0;
    clear = clear_req; clear_req = 0;
    enable = en;
    tvalid = 0; tlast = 0; tuser = 2'b00;
    if (gen_left > 0) begin
      if ($urandom_range(99) < p_valid) begin
        tvalid = 1;
        tlast = ((gen_idx % H) == H - 1);
        tuser[0] = (gen_idx == NB - 1);
        tuser[1] = 1'($urandom_range(1));
        if (gen_idx == inj_line) begin
          tlast = ~tlast;
          if (clear_on_inj) clear = 1;
        end
        if ($urandom_range(99) < p_fault) begin
          if ($urandom_range(1) == 1) tlast = ~tlast;
          else tuser[0] = ~tuser[0];
        end
      end
    end else if (stray_on && $urandom_range(99) < 10) begin
      tvalid = 1;
      tlast = 1'($urandom_range(1));
      tuser = 2'($urandom_range(3));
    end
    tready = ($urandom_range(99) < p_ready);
    if (stall_from >= 0 && gen_left > 0 && gen_idx >= stall_from) tready = 0;
    if (rst_at_idx >= 0 && gen_left > 0 && gen_idx == rst_at_idx && tvalid && tready) begin
      rst = 1;
      rst_at_idx = -1;
    end
  endtask

  task automatic eval_cycle();
    bit beat, expired, col_end, frm_end, x_trig, x_busy, x_done;
    bit e_line, e_frame, e_to, e_ov;
    int pe;
    beat    = tvalid & tready;
    pe      = (period == 0) ? 1 : int'(period);
    expired = (cyc - trig_cyc) >= longint'(pe - 1);
    col_end = (beat_idx % H) == H - 1;
    frm_end = (beat_idx == NB - 1);
    x_trig  = m_trig;
    x_busy  = m_trig | m_frame;
    x_done  = m_frame & beat & frm_end;
    e_line  = m_frame & beat & (tlast != col_end);
    e_frame = beat & (!m_frame | (tuser[0] != frm_end));
    e_to    = m_frame & !beat & (stall + 1 == T);
    e_ov    = (m_trig | m_frame) & expired;

    check_eq("trigger", trigger, x_trig);
    check_eq("busy", busy, x_busy);
    check_eq("frame_done", frame_done, x_done);
    check_eq("frame_cnt", frame_cnt, frames);
    check_eq("err_line", err_line, f_line);
    check_eq("err_frame", err_frame, f_frame);
    check_eq("err_timeout", err_timeout, f_to);
    check_eq("overrun", overrun, f_ov);
    if (trigger) trig_cycles.push_back(cyc);
    if (frame_done) done_cycles.push_back(cyc);

    if (beat && gen_left > 0) begin gen_left--; gen_idx++; end
    if (x_trig) begin gen_left = NB; gen_idx = 0; end

    if (rst) model_reset();
    else begin
      f_line  = e_line  | (f_line  & !clear);
      f_frame = e_frame | (f_frame & !clear);
      f_to    = e_to    | (f_to    & !clear);
      f_ov    = e_ov    | (f_ov    & !clear);
      if (x_done) frames = (frames + 1) % (1 << FCW);
      if (m_trig) begin
        m_trig = 0; m_frame = 1; beat_idx = 0; stall = 0;
      end else if (m_frame) begin
        if (beat) begin
          stall = 0;
          if (frm_end) begin m_frame = 0; m_wait = enable; end
          else beat_idx++;
        end else begin
          stall++;
          if (stall == T) m_frame = 0;
        end
      end else if (m_wait) begin
        if (!enable) m_wait = 0;
        else if (expired) begin m_wait = 0; m_trig = 1; trig_cyc = cyc + 1; end
      end else if (enable || single) begin
        m_trig = 1; trig_cyc = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    en = 0; inj_line = -1; stall_from = -1; rst_at_idx = -1; clear_on_inj = 0;
    stray_on = 0; p_valid = 100; p_ready = 100; p_fault = 0;
    gen_left = 0; gen_idx = 0; rst_cycles = 2;
    step(2);
    trig_cycles.delete(); done_cycles.delete();
    base = cyc;
  endtask

  initial begin
    rst = 1; enable = 0; single = 0; clear = 0; period = '0;
    tvalid = 0; tready = 0; tlast = 0; tuser = '0;
    single_req = 0; clear_req = 0; rst_cycles = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // One-shot frame, compliant generator
    do_reset();
    period = PW'(1000);
    single_req = 1;
    step(45);
    check_eq("s1_ntrig", trig_cycles.size(), 1);
    check_eq("s1_trig_at", qat(trig_cycles, 0) - base, 1);
    check_eq("s1_done_at", qat(done_cycles, 0) - base, 33);
    check_eq("s1_cnt", frame_cnt, 1);

    // Continuous, period 100
    do_reset();
    period = PW'(100);
    en = 1;
    step(215);
    en = 0;
    step(40);
    check_eq("s2_gap1", qat(trig_cycles, 1) - qat(trig_cycles, 0), 100);
    check_eq("s2_gap2", qat(trig_cycles, 2) - qat(trig_cycles, 1), 100);
    check_eq("s2_cnt", frame_cnt, 3);
    check_eq("s2_overrun", overrun, 0);

    // Continuous, period shorter than a frame
    do_reset();
    period = PW'(20);
    en = 1;
    step(80);
    en = 0;
    step(40);
    check_eq("s3_overrun", overrun, 1);
    check_eq("s3_done_to_trig", qat(trig_cycles, 1) - qat(done_cycles, 0), 2);

    // tlast fault on beat 5, clear, then clear racing a new fault
    do_reset();
    period = PW'(1000);
    inj_line = 4;
    single_req = 1;
    step(45);
    check_eq("s4_line_set", err_line, 1);
    check_eq("s4_cnt", frame_cnt, 1);
    clear_req = 1;
    step(2);
    check_eq("s4_line_cleared", err_line, 0);
    clear_on_inj = 1;
    single_req = 1;
    step(45);
    check_eq("s4_line_race", err_line, 1);

    // Stall after beat 10
    do_reset();
    period = PW'(1000);
    stall_from = 10;
    single_req = 1;
    step(100);
    check_eq("s5_timeout", err_timeout, 1);
    check_eq("s5_busy", busy, 0);
    check_eq("s5_cnt", frame_cnt, 0);
    stall_from = -1;
    step(40);
    check_eq("s5_stray", err_frame, 1);

    // Reset on beat 16, generator keeps going
    do_reset();
    period = PW'(1000);
    rst_at_idx = 15;
    single_req = 1;
    step(60);
    check_eq("s6_stray", err_frame, 1);
    check_eq("s6_ntrig", trig_cycles.size(), 1);
    check_eq("s6_cnt", frame_cnt, 0);

    // Back-to-back frames, counter wrap
    do_reset();
    period = '0;
    en = 1;
    step(570);
    en = 0;
    step(50);
    check_eq("s8_wrap_cnt", frame_cnt, 17 % (1 << FCW));

    // Randomized traffic
    do_reset();
    stray_on = 1; p_valid = 70; p_fault = 3; p_ready = 80;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 250) p_ready = (p_ready == 80) ? 3 : 80;
      if ($urandom_range(99) < 2) en = ~en;
      if ($urandom_range(99) < 3) single_req = 1;
      if ($urandom_range(99) < 2) clear_req = 1;
      if ($urandom_range(999) < 3) rst_cycles = 1;
      if (!m_trig && !m_frame && !m_wait && $urandom_range(99) < 5)
        period = PW'($urandom_range(40));
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
